// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with Baud_set-selected divisor; outputs are registered one cycle behind the FSM.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_transmit #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [2:0] Baud_set,
  input  logic [7:0] Data,
  input  logic       send_en,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [13:0] DIV_4800   = 14'(CLK_HZ / 4800);
  localparam logic [13:0] DIV_9600   = 14'(CLK_HZ / 9600);
  localparam logic [13:0] DIV_115200 = 14'(CLK_HZ / 115200);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state, state_n;
  logic [13:0] baud_cnt, cnt_n;
  logic [13:0] div_q, div_n, sel_div;
  logic [2:0]  bit_idx, idx_n;
  logic [7:0]  data_q, data_n;
  logic        line, bit_end;

  always_comb begin
    case (Baud_set)
      3'd0:    sel_div = DIV_4800;
      3'd1:    sel_div = DIV_9600;
      default: sel_div = DIV_115200;
    endcase
  end

  assign bit_end = (baud_cnt == div_q - 14'd1);

  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? 14'd0 : baud_cnt + 14'd1;
    idx_n   = bit_idx;
    data_n  = data_q;
    div_n   = div_q;
    line    = 1'b1;
    case (state)
      IDLE: begin
        cnt_n = 14'd0;
        if (send_en) begin
          state_n = START;
          data_n  = Data;
          div_n   = sel_div;
          idx_n   = 3'd0;
        end
      end
      START: begin
        line = 1'b0;
        if (bit_end) begin
          state_n = DATA;
          idx_n   = 3'd0;
        end
      end
      DATA: begin
        line = data_q[bit_idx];
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line = ^data_q;
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        line = 1'b1;
        if (bit_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are flopped from the pre-edge state, so the pad sees the FSM one cycle later.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      div_q    <= '0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= cnt_n;
      bit_idx  <= idx_n;
      data_q   <= data_n;
      div_q    <= div_n;
      uart_tx  <= line;
      tx_busy  <= (state != IDLE);
      tx_done  <= tx_busy && (state == IDLE);
    end
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Scoreboard bench for uart_transmit: driver pushes expected frames, a line monitor decodes and checks them.
module tb_uart_transmit;
  localparam int CLK_HZ = 1_000_000;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] Baud_set = 3'd0;
  logic [7:0] Data = 8'd0;
  logic       send_en = 1'b0;
  logic       uart_tx, tx_busy, tx_done;

  uart_transmit #(.CLK_HZ(CLK_HZ)) dut (
    .sysclk(sysclk), .rst(rst), .Baud_set(Baud_set), .Data(Data),
    .send_en(send_en), .uart_tx(uart_tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0, n_tot = 0;
  int   abort_req = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  bit   in_frame = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;
  always @(negedge sysclk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  function automatic int div_of(input int b);
    int baud;
    baud = (b == 0) ? 4800 : (b == 1) ? 9600 : 115200;
    return CLK_HZ / baud;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  task automatic rx_frame();
    exp_t      e;
    logic [10:0] bits;
    bit        stable, busy_ok;
    int        abort0;
    stable  = 1'b1;
    busy_ok = 1'b1;
    abort0  = abort_req;
    bits    = '0;
    if (sb.size() == 0) begin
      chk("spurious_frame", 32'd1, 32'd0);
      for (int n = 0; n < 30000 && uart_tx !== 1'b1; n++) @(negedge sysclk);
      return;
    end
    e = sb.pop_front();
    chk("start_cycle", cyc, e.start);
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < e.div; c++) begin
        if (!(b == 0 && c == 0)) @(negedge sysclk);
        if (abort_req != abort0) return;
        if (c == 0) bits[b] = uart_tx;
        else if (uart_tx !== bits[b]) stable = 1'b0;
        if (tx_busy !== 1'b1) busy_ok = 1'b0;
      end
    end
    @(negedge sysclk);
    if (abort_req != abort0) return;
    chk("done_pulse", {29'd0, tx_done, tx_busy, uart_tx}, 32'b101);
    chk("start_bit", {31'd0, bits[0]}, 32'd0);
    chk("data_byte", {24'd0, bits[8:1]}, {24'd0, e.data});
`ifdef UART_TX_PARITY_EN
    chk("parity_bit", {31'd0, bits[9]}, {31'd0, ^e.data});
`endif
    chk("stop_bit", {31'd0, bits[NB-1]}, 32'd1);
    chk("bit_width", {31'd0, stable}, 32'd1);
    chk("busy_in_frame", {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge sysclk);
      if (!rst && uart_tx === 1'b0) begin
        in_frame = 1'b1;
        rx_frame();
        in_frame = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || in_frame) && n < 30000) begin
      @(negedge sysclk);
      n++;
    end
    if (n >= 30000) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge sysclk);
  endtask

  // Caller is at a negedge; the request is taken on the next rising edge.
  task automatic start_req(input logic [7:0] d, input logic [2:0] b, output int acc);
    exp_t e;
    Data     = d;
    Baud_set = b;
    send_en  = 1'b1;
    acc      = cyc + 1;
    e.data   = d;
    e.div    = div_of(int'(b));
    e.start  = acc + 1;
    sb.push_back(e);
    exp_done++;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] b);
    int acc;
    wait_idle();
    start_req(d, b, acc);
    @(negedge sysclk);
    send_en = 1'b0;
  endtask

  initial begin
    int acc, n;
    exp_t e2;
    repeat (3) @(negedge sysclk);
    chk("reset_tx", {31'd0, uart_tx}, 32'd1);
    chk("reset_busy", {31'd0, tx_busy}, 32'd0);
    chk("reset_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);

    send(8'h55, 3'd2);
    send(8'hA3, 3'd0);
    send(8'h96, 3'd7);
    send(8'h07, 3'd2);
    send(8'h03, 3'd1);

    // busy rejection with send_en held, then with a short pulse
    send(8'h5A, 3'd1);
    repeat (200) @(negedge sysclk);
    Data    = 8'hFF;
    send_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      Baud_set = 3'($urandom_range(0, 7));
      @(negedge sysclk);
    end
    send_en = 1'b0;
    send(8'h81, 3'd2);
    repeat (10) @(negedge sysclk);
    Data = 8'hFF; Baud_set = 3'd0; send_en = 1'b1;
    repeat (3) @(negedge sysclk);
    send_en = 1'b0;

    // back-to-back: second request held so it lands on the tx_done edge
    wait_idle();
    start_req(8'h00, 3'd2, acc);
    @(negedge sysclk);
    Data = 8'hFF;
    e2.data  = 8'hFF;
    e2.div   = div_of(2);
    e2.start = acc + 2 + NB * div_of(2);
    sb.push_back(e2);
    exp_done++;
    n = 0;
    while (cyc < acc + 1 + NB * div_of(2) && n < 30000) begin
      @(negedge sysclk);
      n++;
    end
    send_en = 1'b0;

    // reset in the middle of data bit 3
    wait_idle();
    start_req(8'hC5, 3'd2, acc);
    @(negedge sysclk);
    send_en = 1'b0;
    n = 0;
    while (cyc < acc + 1 + 4 * div_of(2) + 3 && n < 30000) begin
      @(negedge sysclk);
      n++;
    end
    #2;
    abort_req++;
    exp_done--;
    rst = 1'b1;
    #1;
    chk("rst_async_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_async_busy", {31'd0, tx_busy}, 32'd0);
    repeat (3) @(negedge sysclk);
    chk("rst_hold_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);
    chk("post_rst_line", {31'd0, uart_tx}, 32'd1);
    send(8'h3C, 3'd2);

    for (int i = 0; i < 12; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 4)) @(negedge sysclk);
      send(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
    end

    wait_idle();
    repeat (5) @(negedge sysclk);
    chk("done_count", done_cnt, exp_done);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout cycles=%0d required<90000", cyc);
    $fatal(1);
  end
endmodule
